// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held until acked; each
// winner keeps ownership for weight+1 consecutive grants before priority rotates.
module weighted_rr_arbiter #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned WeightWidth = 4,
    localparam int unsigned IdxWidth   = ($clog2(NumReq) > 1) ? $clog2(NumReq) : 1
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    input  logic                          en_i,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq*WeightWidth-1:0] weight_i,
    input  logic                          ack_i,
    output logic                          gnt_valid_o,
    output logic [NumReq-1:0]             gnt_o,
    output logic [IdxWidth-1:0]           gnt_idx_o
);

    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumReq - 1);
    localparam logic [IdxWidth:0]   NumReqW  = (IdxWidth + 1)'(NumReq);

    logic                   gnt_valid_q, gnt_valid_d;
    logic [NumReq-1:0]      gnt_q, gnt_d;
    logic [IdxWidth-1:0]    gnt_idx_q, gnt_idx_d;
    logic [IdxWidth-1:0]    ptr_q, ptr_d;
    logic [IdxWidth-1:0]    owner_q, owner_d;
    logic [WeightWidth-1:0] credit_q, credit_d;
    logic                   turn_active_q, turn_active_d;

    logic [NumReq-1:0][WeightWidth-1:0] weight_arr;
    logic                   ack;
    logic                   issue;
    logic [IdxWidth-1:0]    owner_inc;
    logic [IdxWidth-1:0]    ptr_a;
    logic [WeightWidth-1:0] credit_a;
    logic                   turn_a;
    logic                   pick_valid;
    logic [IdxWidth-1:0]    pick_idx;
    logic [IdxWidth:0]      cand;

    assign weight_arr = weight_i;
    assign ack        = gnt_valid_q && ack_i;
    assign owner_inc  = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

    // Apply the ack first so a same-cycle reissue sees the post-ack pointer and turn.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        ptr_a    = ptr_q;
        credit_a = credit_q;
        turn_a   = turn_active_q;
        if (ack) begin
            if (credit_q == '0) begin
                turn_a = 1'b0;
                ptr_a  = owner_inc;
            end else begin
                credit_a = credit_q - 1'b1;
                ptr_a    = owner_q;
            end
        end
    end

    // Circular first-one search from ptr_a, wrapping at NumReq rather than 2^IdxWidth.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = {1'b0, ptr_a} + (IdxWidth + 1)'(i);
            if (cand >= NumReqW) begin
                cand = cand - NumReqW;
            end
            if (!pick_valid && req_i[cand[IdxWidth-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IdxWidth-1:0];
            end
        end
    end

    assign issue = (!gnt_valid_q || ack_i) && en_i && pick_valid;

    always_comb begin
        gnt_valid_d   = gnt_valid_q;
        gnt_d         = gnt_q;
        gnt_idx_d     = gnt_idx_q;
        owner_d       = owner_q;
        ptr_d         = ptr_a;
        credit_d      = credit_a;
        turn_active_d = turn_a;
        if (issue) begin
            gnt_valid_d = 1'b1;
            gnt_d       = NumReq'(1) << pick_idx;
            gnt_idx_d   = pick_idx;
            ptr_d       = pick_idx;
            // Weight is sampled only when a new turn starts.
            if (!(turn_a && (pick_idx == owner_q))) begin
                owner_d       = pick_idx;
                credit_d      = weight_arr[pick_idx];
                turn_active_d = 1'b1;
            end
        end else if (ack) begin
            gnt_valid_d = 1'b0;
            gnt_d       = '0;
            gnt_idx_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            gnt_valid_q   <= 1'b0;
            gnt_q         <= '0;
            gnt_idx_q     <= '0;
            ptr_q         <= '0;
            owner_q       <= '0;
            credit_q      <= '0;
            turn_active_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates from the same edge values.
            gnt_valid_q   <= gnt_valid_d;
            gnt_q         <= gnt_d;
            gnt_idx_q     <= gnt_idx_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            credit_q      <= credit_d;
            turn_active_q <= turn_active_d;
        end
    end

    assign gnt_valid_o = gnt_valid_q;
    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed bench for weighted_rr_arbiter (NumReq=4 and NumReq=3 instances) with a
// scoreboard queue of expected grants popped one per clock.
module tb_weighted_rr_arbiter;

    typedef struct {
        bit sel;   // 0: four-requester instance, 1: three-requester instance
        bit valid;
        int idx;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        arst_ni;
    logic        en_i;

    logic [3:0]  req4;
    logic [15:0] weight4;
    logic        ack4;
    logic        gv4;
    logic [3:0]  gnt4;
    logic [1:0]  idx4;

    logic [2:0]  req3;
    logic [11:0] weight3;
    logic        ack3;
    logic        gv3;
    logic [2:0]  gnt3;
    logic [1:0]  idx3;

    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    int   step_no = 0;
    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    weighted_rr_arbiter #(.NumReq(4), .WeightWidth(4)) dut4 (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .en_i        (en_i),
        .req_i       (req4),
        .weight_i    (weight4),
        .ack_i       (ack4),
        .gnt_valid_o (gv4),
        .gnt_o       (gnt4),
        .gnt_idx_o   (idx4)
    );

    weighted_rr_arbiter #(.NumReq(3), .WeightWidth(4)) dut3 (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .en_i        (en_i),
        .req_i       (req3),
        .weight_i    (weight3),
        .ack_i       (ack3),
        .gnt_valid_o (gv3),
        .gnt_o       (gnt3),
        .gnt_idx_o   (idx3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit sel, input bit valid, input int idx);
        exp_t e;
        e.sel   = sel;
        e.valid = valid;
        e.idx   = valid ? idx : 0;
        sb.push_back(e);
    endtask

    // Advance one clock, then compare the DUT output against the oldest expectation.
    task automatic step_check();
        exp_t        e;
        logic [31:0] exp_gnt;
        @(posedge clk_i);
        #1;
        step_no++;
        if (sb.size() == 0) begin
            check($sformatf("sb_empty@%0d", step_no), 32'd1, 32'd0);
            return;
        end
        e       = sb.pop_front();
        exp_gnt = e.valid ? (32'd1 << e.idx) : 32'd0;
        if (e.sel) begin
            check($sformatf("valid3@%0d", step_no), 32'(gv3),  32'(e.valid));
            check($sformatf("gnt3@%0d",   step_no), 32'(gnt3), exp_gnt);
            check($sformatf("idx3@%0d",   step_no), 32'(idx3), 32'(e.idx));
        end else begin
            check($sformatf("valid4@%0d", step_no), 32'(gv4),  32'(e.valid));
            check($sformatf("gnt4@%0d",   step_no), 32'(gnt4), exp_gnt);
            check($sformatf("idx4@%0d",   step_no), 32'(idx4), 32'(e.idx));
        end
    endtask

    task automatic expect_step(input bit sel, input bit valid, input int idx);
        push(sel, valid, idx);
        step_check();
    endtask

    initial begin
        int seq3[9]      = '{0, 0, 0, 1, 2, 2, 0, 0, 0};
        int seq_plain[6] = '{0, 1, 2, 3, 0, 1};
        int seq_rst[6]   = '{0, 0, 1, 2, 3, 0};

        arst_ni = 1'b1;
        en_i    = 1'b0;
        req4    = '0;
        weight4 = '0;
        ack4    = 1'b0;
        req3    = '0;
        weight3 = '0;
        ack3    = 1'b0;
        #2 arst_ni = 1'b0;
        #1;
        check("rst_valid4", 32'(gv4),  32'd0);
        check("rst_gnt4",   32'(gnt4), 32'd0);
        check("rst_idx4",   32'(idx4), 32'd0);
        check("rst_valid3", 32'(gv3),  32'd0);
        check("rst_gnt3",   32'(gnt3), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 arst_ni = 1'b1;

        // Three requesters, weights {2,0,1}: wrap must go 2 -> 0.
        en_i    = 1'b1;
        weight3 = {4'd1, 4'd0, 4'd2};
        req3    = 3'b111;
        ack3    = 1'b1;
        foreach (seq3[i]) expect_step(1'b1, 1'b1, seq3[i]);
        req3 = '0;
        expect_step(1'b1, 1'b0, 0);

        // Plain round robin, all weights zero.
        req4 = 4'b1111;
        ack4 = 1'b1;
        foreach (seq_plain[i]) expect_step(1'b0, 1'b1, seq_plain[i]);
        req4 = '0;
        expect_step(1'b0, 1'b0, 0);

        // Grant to 1 held without ack while requester 0 rises.
        req4 = 4'b0010;
        ack4 = 1'b0;
        expect_step(1'b0, 1'b1, 1);
        req4 = 4'b0011;
        repeat (5) expect_step(1'b0, 1'b1, 1);
        weight4 = 16'h0003;
        ack4    = 1'b1;
        expect_step(1'b0, 1'b1, 0);

        // Owner 0 (weight 3) drops after two acked grants; 2 takes a full turn.
        req4 = 4'b0101;
        expect_step(1'b0, 1'b1, 0);
        req4    = 4'b0100;
        weight4 = 16'h0103;
        expect_step(1'b0, 1'b1, 2);
        req4 = 4'b0101;
        expect_step(1'b0, 1'b1, 2);
        expect_step(1'b0, 1'b1, 0);

        // en_i low: outstanding grant holds until acked, then nothing is issued.
        en_i = 1'b0;
        ack4 = 1'b0;
        repeat (2) expect_step(1'b0, 1'b1, 0);
        ack4 = 1'b1;
        repeat (3) expect_step(1'b0, 1'b0, 0);
        ack4 = 1'b0;
        en_i = 1'b1;
        expect_step(1'b0, 1'b1, 0);

        // Reset mid-grant (owner 0, credit 2) drops the grant at once.
        arst_ni = 1'b0;
        #1;
        check("midrst_valid4", 32'(gv4),  32'd0);
        check("midrst_gnt4",   32'(gnt4), 32'd0);
        check("midrst_idx4",   32'(idx4), 32'd0);
        @(posedge clk_i);
        #1 arst_ni = 1'b1;
        weight4 = 16'h0001;
        req4    = 4'b1111;
        ack4    = 1'b1;
        foreach (seq_rst[i]) expect_step(1'b0, 1'b1, seq_rst[i]);

        // Maximum weight on requester 3: sixteen grants, then rotation.
        weight4 = 16'hF000;
        req4    = 4'b1100;
        expect_step(1'b0, 1'b1, 2);
        repeat (16) expect_step(1'b0, 1'b1, 3);
        expect_step(1'b0, 1'b1, 2);

        // Single requester is regranted on every ack.
        req4 = 4'b0100;
        repeat (3) expect_step(1'b0, 1'b1, 2);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
- Weighted round-robin arbiter for any requester count (NumReq need not be a power of two).
- Issues a registered one-hot grant with a valid/ack handshake.
- Each winner may keep ownership for a programmable number of back-to-back grants (its weight) before priority rotates.
- Intended for shared-port and bus front-ends where plain round-robin fairness is not enough and a grant must stay stable until the consumer accepts it.

Parameters:
- NumReq, 4, number of requesters, >= 2, need not be a power of two.
- WeightWidth, 4, width of each per-requester weight field.
- IdxWidth (localparam), max(1, $clog2(NumReq)), width of grant index and priority pointer.

Ports:
- clk_i  input  1  clock.
- arst_ni  input  1  asynchronous active-low reset.
- en_i  input  1  allows a new grant to be issued; an outstanding grant is unaffected.
- req_i  input  NumReq  request vector; a requester must hold its bit high until its grant is acked.
- weight_i  input  NumReq*WeightWidth  per-requester weight; weight w means w+1 consecutive grants per turn.
- ack_i  input  1  consumer accepts the current grant; ignored while gnt_valid_o=0.
- gnt_valid_o  output  1  a grant is outstanding.
- gnt_o  output  NumReq  one-hot grant; all zeros when gnt_valid_o=0.
- gnt_idx_o  output  IdxWidth  binary index of the granted requester; 0 when idle.

Behaviour:
- Reset (async assert, sync deassert): gnt_valid_o=0, gnt_o=0, gnt_idx_o=0, ptr=0, owner=0, credit=0, turn_active=0. A reset while a grant is outstanding drops the grant immediately, with no ack needed.
- Internal state:
  - ptr: highest-priority index.
  - owner: index of the last winner.
  - credit: grants remaining in the current turn, WeightWidth bits.
  - turn_active: a turn is in progress.
- Pick (combinational): first index s with req_i[s]=1, searching ptr, ptr+1, ..., wrapping modulo NumReq (wrap NumReq-1 -> 0, no power-of-two aliasing). No request means no pick.
- Issue slot: a cycle where (gnt_valid_o=0 or ack_i=1) and en_i=1 and a pick exists.
  - On the next edge: gnt_valid_o=1, gnt_o=onehot(s), gnt_idx_o=s, ptr<=s.
  - If turn_active=1 and s==owner, the turn continues and credit is unchanged.
  - Otherwise a new turn starts: owner<=s, credit<=weight_i[s], turn_active<=1. Weight is sampled only at turn start.
- Latency: request to grant is 1 cycle. Back-to-back grants are possible: an ack at cycle N with a valid pick gives a new grant at N+1.
- Ack handling (gnt_valid_o=1 and ack_i=1):
  - If credit==0: turn_active<=0 and ptr<=(owner+1) mod NumReq.
  - Else: credit<=credit-1 and ptr stays at owner.
  - The pick for a same-cycle reissue uses the updated ptr and turn state, so the ack and reissue apply in one edge.
- Ack with no issue slot (en_i=0 or no request): the next cycle has gnt_valid_o=0, gnt_o=0, gnt_idx_o=0.
- Stable grant: while gnt_valid_o=1 and ack_i=0, all grant outputs and state hold. There is no preemption, even from a higher-priority requester or when en_i falls.
- Owner drops its request mid-turn:
  - The pick searches from ptr=owner and finds the next requester, which starts a new turn with its own credit.
  - The old owner's unused credit is forfeited.
  - The rotation point is that new winner, not owner+1.
- Max weight (all ones): 2^WeightWidth grants per turn; the credit never underflows.
- Single active requester: granted repeatedly, one grant per ack, regardless of weight.

Test Plan:
- NumReq=4, all weights 0, req_i=4'b1111, ack every grant cycle -> grant indices 0,1,2,3,0,1... with a new grant every cycle, gnt_o one-hot each cycle.
- NumReq=3 (non-power-of-two), weights {2,0,1} for requesters 0,1,2, all requesting, immediate acks -> sequence 0,0,0,1,2,2,0,0,0; index never reaches 3.
- Hold check: grant to requester 1, ack_i=0 for 5 cycles while req_i[0] rises -> gnt_o=4'b0010 and gnt_idx_o=1 stable for all 5 cycles; after the ack the next grant follows the rotation.
- Owner with weight 3 drops its request after 2 acked grants while requester 2 requests -> next grant is to 2 with credit 2's weight; requester 0 regains priority only after 2's turn ends.
- en_i=0 with requests pending -> gnt_valid_o stays 0. An outstanding grant with en_i falling stays valid until acked, then goes idle. en_i rising -> grant appears 1 cycle later.
- Assert arst_ni low for one cycle mid-grant with credit=2 -> gnt_valid_o=0 and gnt_o=0 immediately. After release with all requesting, the first grant goes to index 0 with a freshly loaded credit.
